pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for a five-stage Y86-64 style processor.
//
// Detects load-use, return and mispredict hazards and drives the stall and
// bubble controls of the pipeline registers. It also owns the predicted-PC
// register and a RUN/DRAIN/HALTED exception state machine.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   f_predPC  [63:0]           predicted next PC from fetch
//   F_predPC  [63:0]           registered predicted PC (RST_PC after reset)
//   D_icode, E_icode, M_icode  icodes in the D/E/M pipeline registers
//   E_dstM                     load destination in E (4'hF = none)
//   d_srcA, d_srcB             decode source registers (4'hF = none)
//   M_cnd                      branch condition held in M
//   m_stat, W_stat             stage status (AOK=1, HLT=2, ADR=3, INS=4)
//   F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall
//                              pipeline-register controls
//   set_cc                     condition-code write enable for execute
//   halted                     processor stopped
//   cyc_cnt, bub_cnt, mis_cnt  performance counters
//
// Configuration macro: PIPE_CTRL_PERF_EN builds the performance counters.
// When it is undefined the counter ports are tied to zero and no counter
// flops exist.
module pipe_ctrl #(
  parameter logic [63:0] RST_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] f_predPC,
  output logic [63:0] F_predPC,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  M_icode,
  input  logic [3:0]  E_dstM,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic        M_cnd,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  W_stat,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        W_stall,
  output logic        set_cc,
  output logic        halted,
  output logic [31:0] cyc_cnt,
  output logic [31:0] bub_cnt,
  output logic [31:0] mis_cnt
);

  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE     = 4'hF;
  localparam logic [2:0] STAT_AOK     = 3'd1;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t state;

  logic load_use;
  logic ret_hazard;
  logic mispredict;
  logic m_ok;
  logic w_ok;

  // Hazard detection. A register id of 4'hF never matches a real source,
  // so a load without a destination cannot cause a load-use stall.
  assign load_use   = ((E_icode == ICODE_MRMOVQ) || (E_icode == ICODE_POPQ)) &&
                      (E_dstM != REG_NONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret_hazard = (D_icode == ICODE_RET) || (E_icode == ICODE_RET) ||
                      (M_icode == ICODE_RET);
  assign mispredict = (M_icode == ICODE_JXX) && !M_cnd;
  assign m_ok       = (m_stat == STAT_AOK);
  assign w_ok       = (W_stat == STAT_AOK);

  // Stall/bubble controls are purely combinational so they act in the same
  // cycle as the hazard. When load-use and mispredict coincide, D is both
  // stalled and bubbled; the bubble wins because the instruction in D is on
  // the wrong path anyway.
  always_comb begin
    F_stall  = load_use || ret_hazard || (state != RUN);
    D_stall  = load_use;
    D_bubble = mispredict || (ret_hazard && !load_use);
    E_bubble = mispredict || load_use;
    M_bubble = (state != RUN);
    W_stall  = (state == HALTED);
    set_cc   = (state == RUN) && (E_icode == ICODE_OPQ) && m_ok && w_ok;
    halted   = (state == HALTED);
  end

  // Exception state machine. A bad status in W halts from any state and
  // takes priority; a bad status in M only starts draining. Once draining,
  // the machine waits for the excepting instruction to reach W even if M
  // looks clean again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      if (!w_ok) begin
        state <= HALTED;
      end else if ((state == RUN) && !m_ok) begin
        state <= DRAIN;
      end
    end
  end

  // Predicted PC register, frozen whenever fetch is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F_predPC <= RST_PC;
    end else if (!F_stall) begin
      F_predPC <= f_predPC;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Performance counters run in RUN and DRAIN and freeze once halted so the
  // final values describe the completed program. They wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      bub_cnt <= '0;
      mis_cnt <= '0;
    end else if (state != HALTED) begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (D_bubble || E_bubble) begin
        bub_cnt <= bub_cnt + 32'd1;
      end
      if (mispredict) begin
        mis_cnt <= mis_cnt + 32'd1;
      end
    end
  end
`else
  assign cyc_cnt = '0;
  assign bub_cnt = '0;
  assign mis_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl.
// The stimulus process drives inputs on the falling edge and pushes the
// response predicted by a behavioural model into a queue; a monitor pops
// one entry per cycle shortly before the rising edge and compares.
module tb_pipe_ctrl;

  localparam logic [63:0] RST_PC = 64'h100;
  localparam logic [2:0]  AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  localparam int ST_RUN = 0, ST_DRAIN = 1, ST_HALTED = 2;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] f_predPC;
  logic [63:0] F_predPC;
  logic [3:0]  D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
  logic        M_cnd;
  logic [2:0]  m_stat, W_stat;
  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
  logic        set_cc, halted;
  logic [31:0] cyc_cnt, bub_cnt, mis_cnt;

  pipe_ctrl #(.RST_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_predPC(f_predPC), .F_predPC(F_predPC),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .M_cnd(M_cnd), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc(set_cc), .halted(halted),
    .cyc_cnt(cyc_cnt), .bub_cnt(bub_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        f_stall, d_stall, d_bubble, e_bubble;
    logic        m_bubble, w_stall, set_cc, halted;
    logic [63:0] pc;
    logic [31:0] cyc, bub, mis;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_exp;
  int   n_compared = 0;
  int   n_mismatched = 0;
  bit   stim_done = 1'b0;

  // Reference model state.
  int          m_st;
  logic [63:0] m_pc;
  logic [31:0] m_cyc, m_bub, m_mis;

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st  = ST_RUN;
    m_pc  = RST_PC;
    m_cyc = '0;
    m_bub = '0;
    m_mis = '0;
  endfunction

  // Response predicted straight from the hazard rules.
  function automatic exp_t model_outputs();
    exp_t e;
    bit lu, ret, mis;
    lu  = (E_icode == 4'd5 || E_icode == 4'd11) && E_dstM != 4'hF &&
          (E_dstM == d_srcA || E_dstM == d_srcB);
    ret = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
    mis = (M_icode == 4'd7) && !M_cnd;
    e.f_stall  = lu || ret || (m_st != ST_RUN);
    e.d_stall  = lu;
    e.d_bubble = mis || (ret && !lu);
    e.e_bubble = mis || lu;
    e.m_bubble = (m_st != ST_RUN);
    e.w_stall  = (m_st == ST_HALTED);
    e.set_cc   = (m_st == ST_RUN) && E_icode == 4'd6 && m_stat == AOK && W_stat == AOK;
    e.halted   = (m_st == ST_HALTED);
    e.pc  = m_pc;
    e.cyc = m_cyc;
    e.bub = m_bub;
    e.mis = m_mis;
    return e;
  endfunction

  function automatic void model_edge(input exp_t e);
    if (!rst_n) return;
    if (!e.f_stall) m_pc = f_predPC;
    if (PERF && m_st != ST_HALTED) begin
      m_cyc = m_cyc + 32'd1;
      if (e.d_bubble || e.e_bubble) m_bub = m_bub + 32'd1;
      if (M_icode == 4'd7 && !M_cnd) m_mis = m_mis + 32'd1;
    end
    if (W_stat != AOK) m_st = ST_HALTED;
    else if (m_st == ST_RUN && m_stat != AOK) m_st = ST_DRAIN;
  endfunction

  // Called right after inputs change; leaves time at +3 for direct checks.
  task automatic apply_stimulus();
    cur_exp = model_outputs();
    exp_q.push_back(cur_exp);
    #3;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge(cur_exp);
    @(negedge clk);
  endtask

  task automatic set_nop();
    D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1;
    E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
    M_cnd = 1'b1; m_stat = AOK; W_stat = AOK;
  endtask

  function automatic logic [3:0] rand_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'hF : 4'(r);
  endfunction

  function automatic logic [3:0] rand_icode();
    logic [3:0] pool [8];
    pool = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11};
    return pool[$urandom_range(0, 7)];
  endfunction

  function automatic logic [2:0] rand_stat(input int pct_bad);
    if ($urandom_range(0, 99) < pct_bad) return 3'($urandom_range(2, 4));
    return AOK;
  endfunction

  // Monitor: one comparison set per cycle, one time unit before rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("F_stall", 64'(F_stall), 64'(e.f_stall));
        check_output("D_stall", 64'(D_stall), 64'(e.d_stall));
        check_output("D_bubble", 64'(D_bubble), 64'(e.d_bubble));
        check_output("E_bubble", 64'(E_bubble), 64'(e.e_bubble));
        check_output("M_bubble", 64'(M_bubble), 64'(e.m_bubble));
        check_output("W_stall", 64'(W_stall), 64'(e.w_stall));
        check_output("set_cc", 64'(set_cc), 64'(e.set_cc));
        check_output("halted", 64'(halted), 64'(e.halted));
        check_output("F_predPC", F_predPC, e.pc);
        check_output("cyc_cnt", 64'(cyc_cnt), 64'(e.cyc));
        check_output("bub_cnt", 64'(bub_cnt), 64'(e.bub));
        check_output("mis_cnt", 64'(mis_cnt), 64'(e.mis));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit expired, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    logic [31:0] mis_before;
    int halt_cycles;
    set_nop();
    f_predPC = 64'h0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state
    apply_stimulus();
    check_output("rst_pc", F_predPC, 64'h100);
    check_output("rst_halted", 64'(halted), 64'd0);
    check_output("rst_cyc", 64'(cyc_cnt), 64'd0);
    finish_cycle();

    // Release and load first predicted PC
    rst_n = 1'b1;
    f_predPC = 64'h10A;
    apply_stimulus();
    check_output("rel_pc_hold", F_predPC, 64'h100);
    finish_cycle();
    apply_stimulus();
    check_output("rel_pc_load", F_predPC, 64'h10A);
    finish_cycle();

    // Load-use hazard
    E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3; f_predPC = 64'h20;
    apply_stimulus();
    check_output("lu_F_stall", 64'(F_stall), 64'd1);
    check_output("lu_D_stall", 64'(D_stall), 64'd1);
    check_output("lu_E_bubble", 64'(E_bubble), 64'd1);
    check_output("lu_D_bubble", 64'(D_bubble), 64'd0);
    finish_cycle();
    apply_stimulus();
    check_output("lu_pc_hold", F_predPC, 64'h10A);
    finish_cycle();
    set_nop();

    // Return moving down the pipe
    for (int i = 0; i < 4; i++) begin
      set_nop();
      if (i == 0) D_icode = 4'd9;
      if (i == 1) E_icode = 4'd9;
      if (i == 2) M_icode = 4'd9;
      apply_stimulus();
      check_output("ret_F_stall", 64'(F_stall), (i < 3) ? 64'd1 : 64'd0);
      check_output("ret_D_bubble", 64'(D_bubble), (i < 3) ? 64'd1 : 64'd0);
      finish_cycle();
    end

    // Mispredict together with load-use
    set_nop();
    M_icode = 4'd7; M_cnd = 1'b0;
    E_icode = 4'd11; E_dstM = 4'd2; d_srcB = 4'd2;
    mis_before = m_mis;
    apply_stimulus();
    check_output("mislu_D_bubble", 64'(D_bubble), 64'd1);
    check_output("mislu_E_bubble", 64'(E_bubble), 64'd1);
    check_output("mislu_D_stall", 64'(D_stall), 64'd1);
    finish_cycle();
    set_nop();
    apply_stimulus();
    check_output("mis_cnt_step", 64'(mis_cnt), PERF ? 64'(mis_before + 32'd1) : 64'd0);
    finish_cycle();

    // Exception: drain, linger, halt, asynchronous reset
    m_stat = ADR;
    apply_stimulus();
    finish_cycle();
    m_stat = AOK; E_icode = 4'd6;
    apply_stimulus();
    check_output("drain_M_bubble", 64'(M_bubble), 64'd1);
    check_output("drain_set_cc", 64'(set_cc), 64'd0);
    check_output("drain_F_stall", 64'(F_stall), 64'd1);
    finish_cycle();
    W_stat = ADR;
    apply_stimulus();
    check_output("drain_stay", 64'(M_bubble), 64'd1);
    finish_cycle();
    apply_stimulus();
    check_output("halt_halted", 64'(halted), 64'd1);
    check_output("halt_W_stall", 64'(W_stall), 64'd1);
    finish_cycle();
    set_nop();
    #2;
    rst_n = 1'b0;
    model_reset();
    cur_exp = model_outputs();
    exp_q.push_back(cur_exp);
    #1;
    check_output("async_halted", 64'(halted), 64'd0);
    check_output("async_W_stall", 64'(W_stall), 64'd0);
    finish_cycle();
    rst_n = 1'b1;
    f_predPC = 64'h40;
    apply_stimulus();
    finish_cycle();

`ifdef PIPE_CTRL_PERF_EN
    // Counter wrap
    force dut.cyc_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_cnt;
    m_cyc = 32'hFFFF_FFFF;
    apply_stimulus();
    finish_cycle();
    apply_stimulus();
    finish_cycle();
    apply_stimulus();
    check_output("cyc_wrap", 64'(cyc_cnt), 64'd1);
    finish_cycle();
`else
    apply_stimulus();
    check_output("no_perf_cyc", 64'(cyc_cnt), 64'd0);
    check_output("no_perf_bub", 64'(bub_cnt), 64'd0);
    check_output("no_perf_mis", 64'(mis_cnt), 64'd0);
    finish_cycle();
`endif

    // Randomized traffic with occasional exceptions and recovery resets
    halt_cycles = 0;
    for (int n = 0; n < 600; n++) begin
      if (m_st == ST_HALTED && halt_cycles > 2) begin
        set_nop();
        rst_n = 1'b0;
        model_reset();
        apply_stimulus();
        finish_cycle();
        rst_n = 1'b1;
        halt_cycles = 0;
      end
      D_icode = rand_icode(); E_icode = rand_icode(); M_icode = rand_icode();
      E_dstM = rand_reg(); d_srcA = rand_reg(); d_srcB = rand_reg();
      M_cnd = 1'($urandom_range(0, 1));
      m_stat = rand_stat(3);
      W_stat = rand_stat(2);
      f_predPC = {$urandom, $urandom};
      if (m_st == ST_HALTED) halt_cycles++;
      apply_stimulus();
      finish_cycle();
    end

    stim_done = 1'b1;
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
